// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/flush controller for the 6-stage pipeline
//
// Purpose:
//   Merges stall requests from ID (load-use), EX (multi-cycle divider) and
//   MEM (data SRAM wait) with exception flushes into one prioritized stall
//   vector, a flush strobe and a redirect PC. A two-state FSM holds EX
//   stalled while the divider runs, and a watchdog aborts a divide that never
//   returns a result.
//
// Optional feature macro: PIPE_STALL_CTRL_PERF_EN
//   When defined, adds three 32-bit wrapping performance counters.
//
// Ports:
//   clk               clock
//   rst               synchronous, active-high reset
//   stallreq_id       load-use hazard request from ID (level)
//   div_start         DIV/DIVU entering the divider (1-cycle pulse)
//   div_ready         divider result valid (1-cycle pulse)
//   stallreq_mem      data SRAM not ready (level)
//   excp_valid        exception/eret commit from MEM (1-cycle pulse)
//   excp_pc           redirect target for excp_valid
//   stall[5:0]        bit0=PC .. bit5=WB, 1 = hold that stage
//   flush             clear all stage registers
//   new_pc            redirect PC, zero unless flush=1
//   div_cancel        1-cycle pulse aborting the in-flight divide
//   div_timeout       sticky watchdog error, cleared only by rst
//   busy              FSM not in IDLE
//   perf_stall_cycles cycles with any stall bit set      (PERF_EN only)
//   perf_div_cycles   cycles spent in DIV_WAIT            (PERF_EN only)
//   perf_flush_cnt    number of flush cycles              (PERF_EN only)

module pipe_stall_ctrl #(
  parameter int unsigned DIV_MAX_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        div_ready,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_cancel,
  output logic        div_timeout,
`ifdef PIPE_STALL_CTRL_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_div_cycles,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        busy
);

  // Stall patterns: each hazard freezes its own stage and everything
  // upstream, the next stage downstream receives a bubble.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(DIV_MAX_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_cancel_q, div_cancel_d;
  logic              div_timeout_q, div_timeout_d;

  logic              in_wait;
  logic              wd_fire;
  logic [5:0]        stall_c;
  logic              flush_c;
  logic [31:0]       new_pc_c;
  logic              excp_cancel_c;

  assign in_wait = (state_q == DIV_WAIT);

  // The watchdog only fires if neither a result nor an exception ends the
  // wait in the final allowed cycle; those exits take precedence.
  assign wd_fire = in_wait && !excp_valid && !div_ready && (cnt_q == WD_LAST);

  // ---------------------------------------------------------------------
  // FSM next state, counter and registered watchdog outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_cancel_d  = 1'b0;
    div_timeout_d = div_timeout_q;

    case (state_q)
      IDLE: begin
        // A divide issued alongside an exception is squashed by the flush,
        // so it must not start a wait.
        if (div_start && !excp_valid) begin
          state_d = DIV_WAIT;
          cnt_d   = '0;
        end
      end
      DIV_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (excp_valid || div_ready) begin
          state_d = IDLE;
        end else if (wd_fire) begin
          state_d       = IDLE;
          div_cancel_d  = 1'b1;
          div_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_cancel_q  <= 1'b0;
      div_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_cancel_q  <= div_cancel_d;
      div_timeout_q <= div_timeout_d;
    end
  end

  // ---------------------------------------------------------------------
  // Combinational stall/flush priority encoder (same-cycle response)
  // ---------------------------------------------------------------------
  always_comb begin
    stall_c       = STALL_NONE;
    flush_c       = 1'b0;
    new_pc_c      = 32'h0;
    excp_cancel_c = 1'b0;

    if (excp_valid) begin
      // Flush overrides every stall: the pipeline is being emptied anyway.
      flush_c       = 1'b1;
      new_pc_c      = excp_pc;
      excp_cancel_c = in_wait;
    end else if (stallreq_mem) begin
      // Wins over a pending divide; the divider keeps running and EX is
      // responsible for holding its result until MEM frees up.
      stall_c = STALL_MEM;
    end else if (div_start || (in_wait && !div_ready)) begin
      // div_ready releases the stall in the same cycle so the result
      // advances out of EX on the next edge.
      stall_c = STALL_EX;
    end else if (stallreq_id) begin
      stall_c = STALL_ID;
    end
  end

  assign stall       = stall_c;
  assign flush       = flush_c;
  assign new_pc      = new_pc_c;
  // Exception-path cancel is immediate; watchdog-path cancel is registered.
  assign div_cancel  = div_cancel_q | excp_cancel_c;
  assign div_timeout = div_timeout_q;
  assign busy        = in_wait;

`ifdef PIPE_STALL_CTRL_PERF_EN
  // ---------------------------------------------------------------------
  // Performance counters (wrap modulo 2^32)
  // ---------------------------------------------------------------------
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [31:0] perf_div_cycles_q,   perf_div_cycles_d;
  logic [31:0] perf_flush_cnt_q,    perf_flush_cnt_d;

  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q;
    perf_div_cycles_d   = perf_div_cycles_q;
    perf_flush_cnt_d    = perf_flush_cnt_q;
    if (stall_c != STALL_NONE) perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
    if (in_wait)               perf_div_cycles_d   = perf_div_cycles_q + 32'd1;
    if (flush_c)               perf_flush_cnt_d    = perf_flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles_q <= 32'h0;
      perf_div_cycles_q   <= 32'h0;
      perf_flush_cnt_q    <= 32'h0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_div_cycles_q   <= perf_div_cycles_d;
      perf_flush_cnt_q    <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_div_cycles   = perf_div_cycles_q;
  assign perf_flush_cnt    = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard testbench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_cancel;
    logic        busy;
    logic        div_timeout;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, div_start, div_ready, stallreq_mem, excp_valid;
  logic [31:0] excp_pc;

  logic [5:0]  stall0, stall1;
  logic        flush0, flush1, div_cancel0, div_cancel1;
  logic        div_timeout0, div_timeout1, busy0, busy1;
  logic [31:0] new_pc0, new_pc1;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] ps0, pd0, pf0, ps1, pd1, pf1;
`endif

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_start(div_start),
    .div_ready(div_ready), .stallreq_mem(stallreq_mem), .excp_valid(excp_valid),
    .excp_pc(excp_pc), .stall(stall0), .flush(flush0), .new_pc(new_pc0),
    .div_cancel(div_cancel0), .div_timeout(div_timeout0),
`ifdef PIPE_STALL_CTRL_PERF_EN
    .perf_stall_cycles(ps0), .perf_div_cycles(pd0), .perf_flush_cnt(pf0),
`endif
    .busy(busy0)
  );

  pipe_stall_ctrl #(.DIV_MAX_CYCLES(4), .CNT_W(8)) dut_wd (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_start(div_start),
    .div_ready(div_ready), .stallreq_mem(stallreq_mem), .excp_valid(excp_valid),
    .excp_pc(excp_pc), .stall(stall1), .flush(flush1), .new_pc(new_pc1),
    .div_cancel(div_cancel1), .div_timeout(div_timeout1),
`ifdef PIPE_STALL_CTRL_PERF_EN
    .perf_stall_cycles(ps1), .perf_div_cycles(pd1), .perf_flush_cnt(pf1),
`endif
    .busy(busy1)
  );

  function automatic obs_t obs_main();
    return {stall0, flush0, new_pc0, div_cancel0, busy0, div_timeout0};
  endfunction

  function automatic obs_t obs_wd();
    return {stall1, flush1, new_pc1, div_cancel1, busy1, div_timeout1};
  endfunction

  function automatic obs_t mk(input logic [5:0] s, input logic f, input logic [31:0] pc,
                              input logic c, input logic b, input logic t);
    return {s, f, pc, c, b, t};
  endfunction

  // Advance one clock and apply new inputs just after the edge.
  task automatic drive(input logic id, input logic ds, input logic dr, input logic mem,
                       input logic ev, input logic [31:0] pc);
    @(posedge clk);
    #1;
    stallreq_id  = id;
    div_start    = ds;
    div_ready    = dr;
    stallreq_mem = mem;
    excp_valid   = ev;
    excp_pc      = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stallreq_id = 0; div_start = 0; div_ready = 0; stallreq_mem = 0;
    excp_valid = 0; excp_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    do_reset();
    exp_q.push_back(mk(6'b000000, 0, 32'h0, 0, 0, 0));
    exp_q.push_back(mk(6'b000000, 0, 32'h0, 0, 0, 0));
    @(negedge clk);
    g = obs_main(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_main got=%h exp=%h", g, e); end
    g = obs_wd(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_wd got=%h exp=%h", g, e); end
  endtask

  task automatic test_id_stall();
    obs_t e, g;
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, 0, 0, 0, 0, 32'h0);
      exp_q.push_back(mk(i == 0 ? 6'b000111 : 6'b000000, 0, 32'h0, 0, 0, 0));
      @(negedge clk);
      g = obs_main(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL id_stall cyc=%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  // div_start at relative cycle 0, div_ready at cycle 10.
  task automatic test_div();
    obs_t e, g;
    for (int i = 0; i < 12; i++) begin
      drive(0, i == 0, i == 10, 0, 0, 32'h0);
      exp_q.push_back(mk(i < 10 ? 6'b001111 : 6'b000000, 0, 32'h0, 0,
                         (i >= 1 && i <= 10), 0));
      @(negedge clk);
      g = obs_main(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL div cyc=%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_excp();
    obs_t e, g;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin drive(0, 1, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 0, 0); end
        1, 2, 3: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 1, 0); end
        4: begin drive(0, 0, 0, 0, 1, 32'hBFC00380); e = mk(6'b000000, 1, 32'hBFC00380, 1, 1, 0); end
        5: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b000000, 0, 32'h0, 0, 0, 0); end
        6: begin drive(1, 0, 0, 1, 1, 32'h80000180); e = mk(6'b000000, 1, 32'h80000180, 0, 0, 0); end
        7: begin drive(0, 1, 0, 0, 1, 32'h00001234); e = mk(6'b000000, 1, 32'h00001234, 0, 0, 0); end
        default: begin drive(0, 0, 0, 0, 0, 32'hDEADBEEF); e = mk(6'b000000, 0, 32'h0, 0, 0, 0); end
      endcase
      exp_q.push_back(e);
      @(negedge clk);
      g = obs_main(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL excp cyc=%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_mem_in_div();
    obs_t e, g;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin drive(0, 1, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 0, 0); end
        1: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 1, 0); end
        2: begin drive(1, 0, 0, 1, 0, 32'h0); e = mk(6'b011111, 0, 32'h0, 0, 1, 0); end
        3: begin drive(1, 0, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 1, 0); end
        4: begin drive(1, 0, 1, 0, 0, 32'h0); e = mk(6'b000111, 0, 32'h0, 0, 1, 0); end
        default: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b000000, 0, 32'h0, 0, 0, 0); end
      endcase
      exp_q.push_back(e);
      @(negedge clk);
      g = obs_main(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL mem_in_div cyc=%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_ready_idle();
    obs_t e, g;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, i == 0, 0, 0, 32'h0);
      exp_q.push_back(mk(6'b000000, 0, 32'h0, 0, 0, 0));
      @(negedge clk);
      g = obs_main(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL ready_idle cyc=%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  // DIV_MAX_CYCLES=4 instance: a short divide that completes, then one that
  // never completes and must time out after four wait cycles.
  task automatic test_watchdog();
    obs_t e, g;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      case (i)
        0, 4: begin drive(0, 1, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 0, 0); end
        1, 2: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 1, 0); end
        3: begin drive(0, 0, 1, 0, 0, 32'h0); e = mk(6'b000000, 0, 32'h0, 0, 1, 0); end
        5, 6, 7, 8: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b001111, 0, 32'h0, 0, 1, 0); end
        9: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b000000, 0, 32'h0, 1, 0, 1); end
        default: begin drive(0, 0, 0, 0, 0, 32'h0); e = mk(6'b000000, 0, 32'h0, 0, 0, 1); end
      endcase
      exp_q.push_back(e);
      @(negedge clk);
      g = obs_wd(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL watchdog cyc=%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  // The default instance is still in DIV_WAIT from the watchdog scenario.
  task automatic test_rst_mid_div();
    obs_t e, g;
    drive(0, 0, 0, 0, 0, 32'h0);
    exp_q.push_back(mk(6'b001111, 0, 32'h0, 0, 1, 0));
    @(negedge clk);
    g = obs_main(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL rst_pre got=%h exp=%h", g, e); end
    @(posedge clk); #1; rst = 1'b1;
    exp_q.push_back(mk(6'b001111, 0, 32'h0, 0, 1, 0));
    @(negedge clk);
    g = obs_main(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL rst_during got=%h exp=%h", g, e); end
    @(posedge clk); #1; rst = 1'b0;
    exp_q.push_back(mk(6'b000000, 0, 32'h0, 0, 0, 0));
    exp_q.push_back(mk(6'b000000, 0, 32'h0, 0, 0, 0));
    @(negedge clk);
    g = obs_main(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL rst_after_main got=%h exp=%h", g, e); end
    g = obs_wd(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL rst_after_wd got=%h exp=%h", g, e); end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_div();
    test_excp();
    test_mem_in_div();
    test_ready_idle();
    test_watchdog();
    test_rst_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 6-entry stall bus (PC, IF, ID, EX, MEM, WB).
- Collects stall requests from ID (load-use), EX (multi-cycle divider) and MEM (data SRAM wait), plus exception flush requests.
- Drives one prioritized stall vector, flush and redirect PC to every stage register.
- An internal FSM holds the divider stall across its multi-cycle latency and guards it with a watchdog.

Parameters:
- DIV_MAX_CYCLES, 64, maximum DIV_WAIT cycles before the watchdog aborts; legal range 2..255.
- CNT_W, 8, width of the divider-wait cycle counter; must satisfy 2^CNT_W > DIV_MAX_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stallreq_id  in  1  load-use hazard request from ID, level
- div_start  in  1  one-cycle pulse from EX when a DIV/DIVU enters the divider
- div_ready  in  1  divider result valid, one-cycle pulse
- stallreq_mem  in  1  data SRAM not ready, level
- excp_valid  in  1  exception/eret commit from MEM, one-cycle pulse
- excp_pc  in  32  redirect target for excp_valid
- stall  out  6  bit0=PC … bit5=WB; 1 = Stop
- flush  out  1  clear all stage registers
- new_pc  out  32  redirect PC, valid when flush=1
- div_cancel  out  1  one-cycle pulse: abort the in-flight divide
- div_timeout  out  1  sticky watchdog error
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state=IDLE; counter=0; stall=6'b000000; flush=0; new_pc=0; div_cancel=0; div_timeout=0; busy=0.
- FSM states: IDLE, DIV_WAIT.
  - IDLE→DIV_WAIT on div_start=1 with excp_valid=0; counter cleared to 0.
  - DIV_WAIT→IDLE on div_ready=1, on excp_valid=1, or on the watchdog.
  - Counter increments each cycle in DIV_WAIT.
- Watchdog:
  - Fires when counter==DIV_MAX_CYCLES-1 and div_ready=0 in that cycle.
  - Action: div_timeout<=1 (sticky until rst), div_cancel pulses for 1 cycle, state→IDLE.
- Stall vector is combinational (same-cycle response). First match wins:
  1. excp_valid=1 → stall=6'b000000, flush=1, new_pc=excp_pc.
     - If state=DIV_WAIT, div_cancel=1 that cycle and state→IDLE.
  2. stallreq_mem=1 → stall=6'b011111 (MEM bubbles into WB).
  3. div_start=1 or state=DIV_WAIT with div_ready=0 → stall=6'b001111 (EX holds, bubble into MEM).
  4. stallreq_id=1 → stall=6'b000111 (bubble into EX).
  5. Otherwise stall=6'b000000.
- div_ready=1 in DIV_WAIT releases the stall in that same cycle; the EX result advances on the next edge.
- stallreq_mem during DIV_WAIT:
  - Stall widens to 6'b011111.
  - The FSM keeps counting, and may still exit on div_ready.
  - The divider result must be held by EX, not by this block.
- div_start in the same cycle as excp_valid is ignored (no DIV_WAIT entry).
- div_ready while in IDLE is ignored.
- flush and new_pc are combinational.
  - new_pc=0 when flush=0.
  - div_cancel is registered only for the watchdog path; for the exception path it is combinational.
- rst asserted mid-DIV_WAIT: everything returns to reset values on the next edge. div_cancel is not pulsed.
- busy = (state != IDLE).

Optional Feature:
- Macro: PIPE_STALL_CTRL_PERF_EN.
- When defined, add three outputs:
  - perf_stall_cycles (32): counts cycles with stall!=0.
  - perf_div_cycles (32): counts cycles in DIV_WAIT.
  - perf_flush_cnt (32): counts flush pulses.
- Counters clear on rst and wrap modulo 2^32.
- When undefined, these ports and counters do not exist.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset, then idle → stall=000000, flush=0, busy=0, div_timeout=0.
- stallreq_id=1 for 1 cycle → stall=000111 in that cycle only; 000000 next cycle.
- div_start pulse at cycle 10, div_ready at cycle 20 → stall=001111 from cycle 10 through 19; 000000 at cycle 20; busy=1 from cycle 11 through 20.
- In DIV_WAIT, excp_valid=1 with excp_pc=0xBFC00380 → same cycle flush=1, new_pc=0xBFC00380, stall=000000, div_cancel=1; next cycle state=IDLE.
- In DIV_WAIT, stallreq_mem=1 plus stallreq_id=1 → stall=011111; drop stallreq_mem → 001111.
- With DIV_MAX_CYCLES=4, div_start and no div_ready → 4 stall cycles after the start cycle, then div_cancel pulse, div_timeout=1 held, stall=000000; div_timeout clears only on rst.
